ahb_slave_mem: RTL and testbench

- Parametrised AHB-Lite slave memory model: the next-generation slave-side responder for the AHB bench.
- Generalised in data width, depth, base address and wait states.
- Adds behaviour the bare interface lacks: pipelined address/data phases, programmable wait states, byte-lane writes by HSIZE, and the two-cycle ERROR response.
- Sits behind the AHB interface as the DUT-side slave for driver/monitor bring-up, and as a reusable memory target.

---
 rtl/ahb_slave_mem.sv | 147 ++++++++++++++
 tb/tb_ahb_slave_mem.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite slave memory with programmable wait states, byte-lane writes and a two-cycle ERROR response.
// Latency: WAIT_STATES+1 data-phase cycles per OKAY transfer, exactly 2 cycles per ERROR transfer.
// Backpressure: hreadyout is low during wait cycles and the first ERROR cycle; a new address is taken only when hready=1.
module ahb_slave_mem #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH       = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_STATES = 1
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [DATA_W-1:0] hrdata
);
  localparam int          BYTES = DATA_W / 8;
  localparam int          LG_B  = $clog2(BYTES);
  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'(BYTES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t            r_state, w_state_nx;
  logic [3:0]        r_cnt, w_cnt_nx;
  logic              r_pend, r_write;
  logic [IDX_W-1:0]  r_idx;
  logic [LG_B-1:0]   r_lane;
  logic [2:0]        r_size;
  logic [DATA_W-1:0] r_hrdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] w_off;
  logic [IDX_W-1:0]  w_idx, w_load_idx;
  logic [7:0]        w_amask;
  logic              w_active, w_in_range, w_size_bad, w_misalign, w_err;
  logic              w_accept, w_complete, w_commit, w_load;
  logic [BYTES-1:0]  w_be;
  logic [DATA_W-1:0] w_wr_word, w_rd_word;

  // Decode the address phase on the bus and classify it as accept / error
  always_comb begin
    w_active   = (htrans == 2'b10) || (htrans == 2'b11);
    w_off      = haddr - BASE_ADDR;
    w_in_range = (haddr >= BASE_ADDR) && (64'(w_off) < SPAN);
    w_size_bad = (hsize > 3'(LG_B));
    w_amask    = (8'd1 << hsize) - 8'd1;
    w_misalign = (haddr[7:0] & w_amask) != 8'd0;
    w_err      = !w_in_range || w_size_bad || w_misalign;
    w_idx      = w_off[LG_B +: IDX_W];
    w_accept   = hsel && w_active && hready && ((r_state == S_IDLE) || (r_state == S_ERR2));
    // A pending OKAY transfer completes in the first IDLE cycle after its waits
    w_complete = (r_state == S_IDLE) && r_pend;
    w_commit   = w_complete && r_write;
  end

  // Byte enables from the latched size/lane, merged into the stored word
  always_comb begin
    w_be      = '0;
    w_wr_word = r_mem[r_idx];
    for (int b = 0; b < BYTES; b++) begin
      if ((b >= int'(r_lane)) && (b < int'(r_lane) + (1 << int'(r_size)))) begin
        w_be[b] = 1'b1;
      end
      if (w_be[b]) begin
        w_wr_word[8*b +: 8] = hwdata[8*b +: 8];
      end
    end
  end

  // Pick when and where read data is fetched; forward a same-edge write commit
  always_comb begin
    w_load_idx = (r_state == S_WAIT) ? r_idx : w_idx;
    w_load     = ((r_state == S_WAIT) && (r_cnt == 4'd0) && !r_write) ||
                 (w_accept && !w_err && !hwrite && (WAIT_STATES == 0));
    w_rd_word  = (w_commit && (r_idx == w_load_idx)) ? w_wr_word : r_mem[w_load_idx];
  end

  // Next-state logic for the data-phase FSM
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      S_IDLE, S_ERR2: begin
        w_state_nx = S_IDLE;
        if (w_accept) begin
          if (w_err) begin
            w_state_nx = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_state_nx = S_WAIT;
            w_cnt_nx   = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_state_nx = S_IDLE;
        else               w_cnt_nx   = r_cnt - 4'd1;
      end
      S_ERR1:  w_state_nx = S_ERR2;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State, latched address phase and read-data register
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_pend   <= 1'b0;
      r_write  <= 1'b0;
      r_idx    <= '0;
      r_lane   <= '0;
      r_size   <= 3'd0;
      r_hrdata <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_accept) begin
        r_pend  <= !w_err;
        r_write <= hwrite;
        r_idx   <= w_idx;
        r_lane  <= haddr[LG_B-1:0];
        r_size  <= hsize;
      end else if (w_complete) begin
        r_pend  <= 1'b0;
      end
      if (w_accept && w_err && !hwrite) r_hrdata <= '0;
      else if (w_load)                  r_hrdata <= w_rd_word;
    end
  end

  // Commit write lanes on the completion edge; storage is never reset
  always_ff @(posedge hclk) begin
    if (w_commit) r_mem[r_idx] <= w_wr_word;
  end

  assign hreadyout = !((r_state == S_WAIT) || (r_state == S_ERR1));
  assign hresp     = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign hrdata    = r_hrdata;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: directed pipelined AHB master against two slaves (1 wait state at base 0, 0 wait states at base 0x1000).
// Latency: expected per-transfer data-phase length comes from a byte-level reference model.
// Backpressure: next address phase is held while the slave drives hreadyout low.
module tb_ahb_slave_mem;
  typedef struct {
    logic        sel;
    logic [1:0]  tr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
  } item_t;

  typedef struct {
    int          lat;
    logic        resp;
    logic        rd;
    logic [31:0] rdata;
    logic [31:0] wd;
  } exp_t;

  localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NS = 2'b10, SQ = 2'b11;

  logic             hclk = 1'b0;
  logic [1:0]       hreset, hsel, hwrite;
  logic [1:0][1:0]  htrans;
  logic [1:0][2:0]  hsize;
  logic [1:0][31:0] haddr, hwdata;
  logic             hreadyout0, hreadyout1, hresp0, hresp1;
  logic [31:0]      hrdata0, hrdata1;

  item_t      stim_q[$];
  exp_t       sb[$];
  logic [7:0] mdl [2][1024];
  int         checks = 0;
  int         errors = 0;

  always #5 hclk = ~hclk;

  ahb_slave_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(1)) u_ws1 (
    .hclk(hclk), .hreset(hreset[0]), .hsel(hsel[0]), .haddr(haddr[0]), .htrans(htrans[0]),
    .hwrite(hwrite[0]), .hsize(hsize[0]), .hwdata(hwdata[0]), .hready(hreadyout0),
    .hreadyout(hreadyout0), .hresp(hresp0), .hrdata(hrdata0));

  ahb_slave_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hreset(hreset[1]), .hsel(hsel[1]), .haddr(haddr[1]), .htrans(htrans[1]),
    .hwrite(hwrite[1]), .hsize(hsize[1]), .hwdata(hwdata[1]), .hready(hreadyout1),
    .hreadyout(hreadyout1), .hresp(hresp1), .hrdata(hrdata1));

  function automatic logic get_rdy(input int d);
    return (d != 0) ? hreadyout1 : hreadyout0;
  endfunction
  function automatic logic get_resp(input int d);
    return (d != 0) ? hresp1 : hresp0;
  endfunction
  function automatic logic [31:0] get_rdata(input int d);
    return (d != 0) ? hrdata1 : hrdata0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic s, input logic [1:0] t, input logic w, input logic [2:0] z,
                     input logic [31:0] a, input logic [31:0] wd);
    item_t it;
    it = '{s, t, w, z, a, wd};
    stim_q.push_back(it);
  endtask

  // Reference model: classify the accepted address phase, update bytes, push expectation
  task automatic accept(input int d, input item_t it);
    exp_t        e;
    logic [31:0] base, off, w;
    logic        err;
    int          lane;
    base    = (d != 0) ? 32'h0000_1000 : 32'h0000_0000;
    off     = it.a - base;
    e.wd    = it.wd;
    e.rd    = 1'b0;
    e.rdata = 32'h0;
    e.resp  = 1'b0;
    e.lat   = 1;
    if (!(it.sel && it.tr[1])) begin
      sb.push_back(e);
      return;
    end
    err    = (it.a < base) || (off >= 32'd1024) || (it.sz > 3'd2) ||
             ((it.a & ((32'd1 << it.sz) - 32'd1)) != 32'd0);
    e.lat  = err ? 2 : ((d != 0) ? 1 : 2);
    e.resp = err;
    e.rd   = !it.wr;
    if (!err) begin
      lane = int'(off[1:0]);
      w    = off & ~32'd3;
      if (it.wr) begin
        for (int b = 0; b < (1 << it.sz); b++) mdl[d][int'(off) + b] = it.wd[8*(lane+b) +: 8];
      end else begin
        e.rdata = {mdl[d][int'(w)+3], mdl[d][int'(w)+2], mdl[d][int'(w)+1], mdl[d][int'(w)]};
      end
    end
    sb.push_back(e);
  endtask

  task automatic drive_idle(input int d);
    hsel[d] = 1'b0; htrans[d] = IDL; hwrite[d] = 1'b0; hsize[d] = 3'd0;
    haddr[d] = 32'h0; hwdata[d] = 32'h0;
  endtask

  // Pipelined master: runs the queued address phases, checks each data phase as it completes
  task automatic run(input int d);
    int    guard = 0;
    int    lat   = 0;
    logic  rdy;
    item_t it;
    while ((stim_q.size() > 0 || sb.size() > 0) && guard < 200) begin
      guard++;
      if (stim_q.size() > 0) it = stim_q[0];
      else                   it = '{1'b0, IDL, 1'b0, 3'd0, 32'h0, 32'h0};
      hsel[d] = it.sel; htrans[d] = it.tr; hwrite[d] = it.wr; hsize[d] = it.sz; haddr[d] = it.a;
      hwdata[d] = (sb.size() > 0) ? sb[0].wd : 32'h0;
      @(negedge hclk);
      rdy = get_rdy(d);
      if (sb.size() > 0) begin
        lat++;
        if (!rdy) begin
          chk("wait_hresp", 32'(get_resp(d)), 32'(sb[0].resp));
        end else begin
          chk("latency", 32'(lat), 32'(sb[0].lat));
          chk("hresp", 32'(get_resp(d)), 32'(sb[0].resp));
          if (sb[0].rd) chk("hrdata", get_rdata(d), sb[0].rdata);
          void'(sb.pop_front());
          lat = 0;
        end
      end
      @(posedge hclk);
      if (rdy && stim_q.size() > 0) begin
        accept(d, stim_q[0]);
        void'(stim_q.pop_front());
      end
      #1;
    end
    if (guard >= 200) begin
      chk("seq_timeout", 32'(stim_q.size() + sb.size()), 32'h0);
      stim_q.delete();
      sb.delete();
    end
    drive_idle(d);
  endtask

  initial begin
    hreset = 2'b11;
    drive_idle(0);
    drive_idle(1);
    #1;
    chk("rst_rdy0", 32'(hreadyout0), 32'h1);
    chk("rst_resp0", 32'(hresp0), 32'h0);
    chk("rst_rdata0", hrdata0, 32'h0);
    chk("rst_rdy1", 32'(hreadyout1), 32'h1);
    chk("rst_resp1", 32'(hresp1), 32'h0);
    chk("rst_rdata1", hrdata1, 32'h0);
    repeat (2) @(posedge hclk);
    #1;
    hreset = 2'b00;

    // One wait state: word write then read-back of the same word
    add(1, NS, 1, 3'd2, 32'h10, 32'hDEAD_BEEF);
    add(1, NS, 0, 3'd2, 32'h10, 32'h0);
    // Byte lane write into a cleared word
    add(1, NS, 1, 3'd2, 32'h10, 32'h0000_0000);
    add(1, NS, 1, 3'd0, 32'h13, 32'hA500_0000);
    add(1, NS, 0, 3'd2, 32'h10, 32'h0);
    run(0);

    // ERROR responses: out of range, misaligned halfword, oversize; memory left intact
    add(1, NS, 1, 3'd2, 32'h0, 32'h1122_3344);
    add(1, NS, 0, 3'd2, 32'h400, 32'h0);
    add(1, NS, 1, 3'd1, 32'h1, 32'hFFFF_FFFF);
    add(1, NS, 0, 3'd3, 32'h8, 32'h0);
    add(1, NS, 0, 3'd2, 32'h0, 32'h0);
    run(0);

    // Reset during the wait cycle of a write drops that write
    add(1, NS, 1, 3'd2, 32'h40, 32'hCAFE_F00D);
    add(1, NS, 0, 3'd2, 32'h40, 32'h0);
    run(0);
    hsel[0] = 1'b1; htrans[0] = NS; hwrite[0] = 1'b1; hsize[0] = 3'd2; haddr[0] = 32'h40;
    @(posedge hclk);
    #1;
    hsel[0] = 1'b0; htrans[0] = IDL; hwrite[0] = 1'b0; hwdata[0] = 32'h1234_5678;
    @(negedge hclk);
    chk("rst_mid_wait", 32'(hreadyout0), 32'h0);
    hreset[0] = 1'b1;
    #1;
    chk("rst_mid_rdy", 32'(hreadyout0), 32'h1);
    chk("rst_mid_resp", 32'(hresp0), 32'h0);
    chk("rst_mid_rdata", hrdata0, 32'h0);
    @(posedge hclk);
    #1;
    hreset[0] = 1'b0;
    hwdata[0] = 32'h0;
    add(1, NS, 0, 3'd2, 32'h40, 32'h0);
    run(0);

    // Zero wait states: 4-beat burst write and read with no gap cycles, then same-word write/read
    add(1, NS, 1, 3'd2, 32'h1020, 32'd1);
    add(1, SQ, 1, 3'd2, 32'h1024, 32'd2);
    add(1, SQ, 1, 3'd2, 32'h1028, 32'd3);
    add(1, SQ, 1, 3'd2, 32'h102C, 32'd4);
    add(1, NS, 0, 3'd2, 32'h1020, 32'h0);
    add(1, SQ, 0, 3'd2, 32'h1024, 32'h0);
    add(1, SQ, 0, 3'd2, 32'h1028, 32'h0);
    add(1, SQ, 0, 3'd2, 32'h102C, 32'h0);
    add(1, NS, 1, 3'd2, 32'h1040, 32'hA5A5_0001);
    add(1, NS, 0, 3'd2, 32'h1040, 32'h0);
    run(1);

    // BUSY / IDLE / unselected phases mid-burst are not latched and do not write
    add(1, NS, 1, 3'd2, 32'h103C, 32'd9);
    add(1, NS, 1, 3'd2, 32'h1030, 32'd5);
    add(1, BSY, 1, 3'd2, 32'h1034, 32'h0000_0BAD);
    add(1, SQ, 1, 3'd2, 32'h1034, 32'd6);
    add(1, IDL, 1, 3'd2, 32'h1038, 32'h0000_0BAD);
    add(1, SQ, 1, 3'd2, 32'h1038, 32'd7);
    add(0, NS, 1, 3'd2, 32'h103C, 32'h0000_0BAD);
    add(1, NS, 0, 3'd2, 32'h1030, 32'h0);
    add(1, SQ, 0, 3'd2, 32'h1034, 32'h0);
    add(1, SQ, 0, 3'd2, 32'h1038, 32'h0);
    add(1, SQ, 0, 3'd2, 32'h103C, 32'h0);
    add(1, NS, 0, 3'd2, 32'h0FFC, 32'h0);
    add(1, NS, 0, 3'd2, 32'h1400, 32'h0);
    add(1, NS, 0, 3'd2, 32'h1020, 32'h0);
    run(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
